// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler
//   Latches floor calls into a pending mask and drives a single car over them in
//   SCAN order: the car keeps its direction while calls remain ahead of it and
//   reverses otherwise. Movement is issued one floor at a time as a req/ack
//   handshake to the car datapath; at every served floor the doors are held open
//   for DOOR_TICKS cycles. The car floor (1..FLOORS) is tracked for the display.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   call_req   in   bit i = call for floor i+1 (level or pulse)
//   move_ack   in   car datapath finished the requested one-floor step
//   move_req   out  step request, held until move_ack
//   move_up    out  step direction (1 = up), valid while move_req
//   cur_floor  out  current car floor, 1..FLOORS
//   dir_up     out  current SCAN direction
//   door_open  out  doors open
//   pending    out  latched unserved calls, bit i = floor i+1
//   busy       out  scheduler not idle or calls still pending
module elevator_call_scheduler #(
  parameter int FLOORS     = 7,
  parameter int FLOOR_W    = 3,
  parameter int DOOR_TICKS = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOORS-1:0]  call_req,
  input  logic               move_ack,
  output logic               move_req,
  output logic               move_up,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               dir_up,
  output logic               door_open,
  output logic [FLOORS-1:0]  pending,
  output logic               busy
);

  localparam int                 DWELL_W    = $clog2(DOOR_TICKS + 1);
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DOOR_TICKS - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
  localparam logic [FLOOR_W-1:0] FLOOR_ONE  = FLOOR_W'(1);
  localparam logic [FLOOR_W-1:0] FLOOR_TOP  = FLOOR_W'(FLOORS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_DOOR
  } state_t;

  state_t               r_state;
  logic [FLOOR_W-1:0]   r_cur_floor;
  logic                 r_dir_up;
  logic [FLOORS-1:0]    r_pending;
  logic                 r_move_req;
  logic                 r_move_up;
  logic                 r_door_open;
  logic [DWELL_W-1:0]   r_dwell;
  logic                 r_busy;

  logic [FLOORS-1:0]    w_cur_bit;
  logic [FLOORS-1:0]    w_latched;
  logic                 w_door_hit;
  logic                 w_above;
  logic                 w_below;
  logic                 w_go_up;

  always_comb begin
    w_cur_bit  = FLOORS'(1) << (r_cur_floor - FLOOR_ONE);
    // While the doors are open, a call for this floor only keeps them open; it
    // must not leave a stale pending bit behind.
    w_door_hit = (r_state == S_DOOR) && ((call_req & w_cur_bit) != '0);
    if (r_state == S_DOOR) begin
      w_latched = r_pending | (call_req & ~w_cur_bit);
    end else begin
      w_latched = r_pending | call_req;
    end

    w_above = 1'b0;
    w_below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (r_pending[i]) begin
        if (FLOOR_W'(i + 1) > r_cur_floor) w_above = 1'b1;
        if (FLOOR_W'(i + 1) < r_cur_floor) w_below = 1'b1;
      end
    end
    // SCAN choice folded into one term: go up when calls lie above and either we
    // are already heading up or nothing waits below.
    w_go_up = w_above && (r_dir_up || !w_below);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cur_floor <= FLOOR_ONE;
      r_dir_up    <= 1'b1;
      r_pending   <= '0;
      r_move_req  <= 1'b0;
      r_move_up   <= 1'b0;
      r_door_open <= 1'b0;
      r_dwell     <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((r_pending & w_cur_bit) != '0) begin
            // Serve the current floor; a same-cycle call for it is absorbed too.
            r_pending   <= w_latched & ~w_cur_bit;
            r_dwell     <= DWELL_LOAD;
            r_door_open <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_DOOR;
          end else if (r_pending == '0) begin
            r_pending <= w_latched;
            r_busy    <= (w_latched != '0);
          end else begin
            r_pending  <= w_latched;
            r_dir_up   <= w_go_up;
            r_move_up  <= w_go_up;
            r_move_req <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_STEP;
          end
        end

        S_STEP: begin
          r_pending <= w_latched;
          if (move_ack) begin
            // Bounds guard keeps cur_floor in 1..FLOORS even if the car misbehaves.
            if (r_move_up && (r_cur_floor != FLOOR_TOP)) begin
              r_cur_floor <= r_cur_floor + FLOOR_ONE;
            end else if (!r_move_up && (r_cur_floor != FLOOR_ONE)) begin
              r_cur_floor <= r_cur_floor - FLOOR_ONE;
            end
            r_move_req <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_IDLE;
          end
        end

        S_DOOR: begin
          r_pending <= w_latched;
          if (w_door_hit) begin
            r_dwell <= DWELL_LOAD;
          end else if (r_dwell == '0) begin
            r_door_open <= 1'b0;
            r_busy      <= (w_latched != '0);
            r_state     <= S_IDLE;
          end else begin
            r_dwell <= r_dwell - DWELL_ONE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign move_req  = r_move_req;
  assign move_up   = r_move_up;
  assign cur_floor = r_cur_floor;
  assign dir_up    = r_dir_up;
  assign door_open = r_door_open;
  assign pending   = r_pending;
  assign busy      = r_busy;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb_elevator_call_scheduler
//   Scoreboard bench for elevator_call_scheduler. Call batches are issued while
//   the car is idle; a sweep-level SCAN model turns each batch into the expected
//   sequence of step starts and door openings, which a separate monitor pops and
//   compares as the DUT produces them. Directed scenarios cover door reload,
//   stalled acks, reset mid-step and a call at the current floor.
module tb_elevator_call_scheduler;

  localparam int FLOORS  = 7;
  localparam int FLOOR_W = 3;
  localparam int DT      = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [FLOORS-1:0]  call_req = '0;
  logic               move_ack = 1'b0;
  logic               move_req;
  logic               move_up;
  logic [FLOOR_W-1:0] cur_floor;
  logic               dir_up;
  logic               door_open;
  logic [FLOORS-1:0]  pending;
  logic               busy;

  elevator_call_scheduler #(
    .FLOORS    (FLOORS),
    .FLOOR_W   (FLOOR_W),
    .DOOR_TICKS(DT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .call_req (call_req),
    .move_ack (move_ack),
    .move_req (move_req),
    .move_up  (move_up),
    .cur_floor(cur_floor),
    .dir_up   (dir_up),
    .door_open(door_open),
    .pending  (pending),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_door;
    bit up;
    int floor;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  m_floor  = 1;
  bit  m_dir    = 1'b1;
  bit  mon_en   = 1'b0;
  bit  ack_en   = 1'b1;
  bit  saw_req  = 1'b0;
  int  max_delay = 0;
  int  exp_door_len = DT;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Sweep-level SCAN: serve the current floor if called, then repeatedly pick a
  // direction (keep it if calls lie ahead, else reverse) and visit every called
  // floor that way in order.
  task automatic model_batch(input logic [FLOORS-1:0] mask);
    int  pend[FLOORS+1];
    int  f;
    bit  d;
    int  left;
    bit  ahead;
    ev_t e;
    f = m_floor;
    d = m_dir;
    left = 0;
    pend[0] = 0;
    for (int i = 1; i <= FLOORS; i++) begin
      pend[i] = mask[i-1] ? 1 : 0;
      left += pend[i];
    end
    if (pend[f] != 0) begin
      e.is_door = 1'b1; e.up = 1'b0; e.floor = f;
      exp_q.push_back(e);
      pend[f] = 0;
      left--;
    end
    while (left > 0) begin
      ahead = 1'b0;
      for (int t = 1; t <= FLOORS; t++)
        if (pend[t] != 0 && (d ? (t > f) : (t < f))) ahead = 1'b1;
      if (!ahead) d = !d;
      for (int k = 1; k <= FLOORS; k++) begin
        int t;
        t = d ? k : FLOORS + 1 - k;
        if (pend[t] != 0 && (d ? (t > f) : (t < f))) begin
          while (f != t) begin
            e.is_door = 1'b0; e.up = d; e.floor = f;
            exp_q.push_back(e);
            f = d ? f + 1 : f - 1;
          end
          e.is_door = 1'b1; e.up = 1'b0; e.floor = t;
          exp_q.push_back(e);
          pend[t] = 0;
          left--;
        end
      end
    end
    m_floor = f;
    m_dir   = d;
  endtask

  // Car datapath stand-in: acks each step after a random 0..max_delay cycles.
  initial begin
    int cnt;
    int cur_delay;
    cnt = 0;
    cur_delay = 0;
    forever begin
      @(negedge clk);
      if (rst || move_ack) begin
        move_ack = 1'b0;
        cnt = 0;
      end else if (move_req && ack_en) begin
        if (cnt >= cur_delay) begin
          move_ack  = 1'b1;
          cnt       = 0;
          cur_delay = $urandom_range(0, max_delay);
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: step starts and door openings are popped from the scoreboard.
  initial begin
    bit  prev_req;
    bit  prev_door;
    int  door_len;
    ev_t e;
    prev_req  = 1'b0;
    prev_door = 1'b0;
    door_len  = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (move_req && !prev_req) begin
          saw_req = 1'b1;
          chk("step_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("step_kind_is_step", int'(e.is_door), 0);
            chk("step_move_up", int'(move_up), int'(e.up));
            chk("step_from_floor", int'(cur_floor), e.floor);
          end
        end
        if (door_open && !prev_door) begin
          chk("door_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("door_kind_is_door", int'(e.is_door), 1);
            chk("door_floor", int'(cur_floor), e.floor);
          end
        end
        if (door_open) door_len = prev_door ? door_len + 1 : 1;
        if (!door_open && prev_door) chk("door_open_cycles", door_len, exp_door_len);
      end
      prev_req  = move_req;
      prev_door = door_open;
    end
  end

  task automatic issue(input logic [FLOORS-1:0] mask);
    @(negedge clk);
    call_req = mask;
    model_batch(mask);
    @(negedge clk);
    call_req = '0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    chk({name, "_idle_reached"}, int'(done), 1);
    @(negedge clk);
  endtask

  task automatic wait_req(input string name, input bit level);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (move_req == level) begin
        done = 1'b1;
        break;
      end
    end
    chk({name, "_move_req_edge"}, int'(done), 1);
  endtask

  task automatic post(input string name);
    chk({name, "_cur_floor"}, int'(cur_floor), m_floor);
    chk({name, "_dir_up"}, int'(dir_up), int'(m_dir));
    chk({name, "_pending"}, int'(pending), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_door_open"}, int'(door_open), 0);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_rst_cur_floor"}, int'(cur_floor), 1);
    chk({name, "_rst_dir_up"}, int'(dir_up), 1);
    chk({name, "_rst_move_req"}, int'(move_req), 0);
    chk({name, "_rst_move_up"}, int'(move_up), 0);
    chk({name, "_rst_door_open"}, int'(door_open), 0);
    chk({name, "_rst_pending"}, int'(pending), 0);
    chk({name, "_rst_busy"}, int'(busy), 0);
  endtask

  initial begin
    logic [FLOORS-1:0]  mask;
    logic               mu;
    logic [FLOOR_W-1:0] f0;
    bit                 stable;
    bit                 done;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("init");
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single call to floor 3 from reset.
    issue(7'b0000100);
    wait_idle("t1");
    post("t1");

    // At floor 3 heading up with calls at 1 and 6: 6 first, then reverse to 1.
    issue(7'b0100001);
    wait_idle("t2");
    post("t2");
    chk("t2_dir_down", int'(dir_up), 0);

    // Door reload at floor 4 when the dwell counter reads 2.
    exp_door_len = 2 * DT - 2;
    issue(7'b0001000);
    done = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (door_open) begin
        done = 1'b1;
        break;
      end
    end
    chk("t3_door_reached", int'(done), 1);
    repeat (DT - 3) @(negedge clk);
    call_req = 7'b0001000;
    @(negedge clk);
    call_req = '0;
    chk("t3_pending_bit_clear", int'(pending[3]), 0);
    chk("t3_door_still_open", int'(door_open), 1);
    wait_idle("t3");
    exp_door_len = DT;
    post("t3");

    // Stalled ack: request must stay stable, then one floor on ack.
    ack_en = 1'b0;
    issue(7'b0100000);
    wait_req("t4_rise", 1'b1);
    mu = move_up;
    f0 = cur_floor;
    chk("t4_step_up", int'(mu), 1);
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (move_req !== 1'b1 || move_up !== mu || cur_floor !== f0) stable = 1'b0;
    end
    chk("t4_hold_stable", int'(stable), 1);
    ack_en = 1'b1;
    wait_req("t4_fall", 1'b0);
    chk("t4_one_floor", int'(cur_floor), int'(f0) + 1);
    wait_idle("t4");
    post("t4");

    // Reset while stepping away from floor 5 with calls pending.
    issue(7'b0010000);
    wait_idle("t5a");
    post("t5a");
    mon_en = 1'b0;
    ack_en = 1'b0;
    @(negedge clk);
    call_req = 7'b1000010;
    @(negedge clk);
    call_req = '0;
    wait_req("t5_rise", 1'b1);
    chk("t5_at_floor5", int'(cur_floor), 5);
    chk("t5_pending_nonzero", int'(pending != '0), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("t5");
    rst = 1'b0;
    exp_q.delete();
    m_floor = 1;
    m_dir   = 1'b1;
    ack_en  = 1'b1;
    mon_en  = 1'b1;

    // Call at the current floor while idle: doors open, no step.
    saw_req = 1'b0;
    issue(7'b0000001);
    wait_idle("t6");
    chk("t6_no_move_req", int'(saw_req), 0);
    post("t6");

    // Random batches with random ack latency.
    for (int b = 0; b < 24; b++) begin
      max_delay = $urandom_range(0, 3);
      mask = FLOORS'($urandom_range(1, (1 << FLOORS) - 1));
      issue(mask);
      wait_idle("rnd");
      post("rnd");
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
